// File: rtl/write_buffer_ctrl_if.sv
// write_buffer_ctrl_if
// ---------------------------------------------------------------------------
// Request/response bus used on both sides of the posted-write buffer.
// The cache side and the memory side have the same shape, so one interface
// type serves both:
//   read   - read request, held until ready
//   write  - write request, held until ready (never together with read)
//   addr   - block address
//   wdata  - write data
//   ready  - one-cycle completion
//   rdata  - read data, valid with ready
//
// Modports:
//   master - issues requests (drives read/write/addr/wdata)
//   slave  - services requests (drives ready/rdata)
// ---------------------------------------------------------------------------
interface write_buffer_ctrl_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output read,
        output write,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/write_buffer_ctrl.sv
// write_buffer_ctrl
// ---------------------------------------------------------------------------
// Posted-write buffer between the L1 data cache and main memory. Cache
// writes are absorbed into a DEPTH-entry FIFO in one cycle and drained to
// memory in the background; cache reads are ordered against pending writes
// before they reach memory.
//
// Parameters:
//   DEPTH  - buffer entries (power of two, >= 2)
//   ADDR_W - block address width
//   DATA_W - block data width
//
// Ports:
//   clk      - clock, all state on the rising edge
//   rst      - asynchronous active-high reset
//   cache_if - slave side facing the cache (read/write/addr/wdata in,
//              ready/rdata out; ready is a registered one-cycle pulse)
//   mem_if   - master side facing memory (read/write/addr/wdata out, all
//              registered; ready/rdata in)
//
// Build option WB_FORWARD_EN:
//   defined   - cache reads search the buffer; a hit returns the youngest
//               matching entry without touching memory, a miss goes to
//               memory ahead of the pending drain.
//   undefined - cache reads wait until the buffer has fully drained, then
//               go to memory. No address comparators are built.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no memory request outstanding; pick read issue or drain
// S_DRAIN | mem_write outstanding for the FIFO head entry
// S_READ  | mem_read outstanding for the pending cache read
// ---------------------------------------------------------------------------
module write_buffer_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    write_buffer_ctrl_if.slave  cache_if,
    write_buffer_ctrl_if.master mem_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Buffer storage; only entries below count_q are ever looked at, so the
    // array itself needs no reset.
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              cache_ready_q, cache_ready_d;
    logic [DATA_W-1:0] cache_rdata_q, cache_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              full;
    logic              empty;
    logic              req_ok;
    logic              wr_req;
    logic              rd_req;
    logic              do_enq;
    logic              do_deq;
    logic              rd_hit;
    logic [DATA_W-1:0] hit_data;
    logic              rd_may_issue;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);

    // While the completion pulse is high the cache is still retiring the
    // previous request, so whatever it presents that cycle is stale.
    assign req_ok = !cache_ready_q;
    assign wr_req = req_ok && cache_if.write;
    assign rd_req = req_ok && cache_if.read;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk the live entries oldest to youngest; the last match wins, which
    // gives the youngest write to the address.
    always_comb begin
        rd_hit   = 1'b0;
        hit_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_addr_q[fwd_idx] == cache_if.addr)) begin
                rd_hit   = 1'b1;
                hit_data = fifo_data_q[fwd_idx];
            end
        end
    end

    // A miss cannot see stale data in memory, so it may overtake the drain.
    assign rd_may_issue = 1'b1;
`else
    assign rd_hit       = 1'b0;
    assign hit_data     = '0;
    assign rd_may_issue = empty;
`endif

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        cache_ready_d = 1'b0;
        cache_rdata_d = cache_rdata_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        do_enq        = 1'b0;
        do_deq        = 1'b0;

        // Writes are accepted in every state. Fullness is judged on the
        // registered count, so a slot freed by this cycle's dequeue only
        // becomes usable next cycle.
        if (wr_req && !full) begin
            do_enq        = 1'b1;
            cache_ready_d = 1'b1;
        end

        // A buffered copy is authoritative regardless of what the memory
        // side is doing, so hits are answered in any state. This lets a read
        // that follows a write hit while that write is still draining.
        if (rd_req && rd_hit) begin
            cache_ready_d = 1'b1;
            cache_rdata_d = hit_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rd_req && !rd_hit && rd_may_issue) begin
                    state_d    = S_READ;
                    mem_read_d = 1'b1;
                    mem_addr_d = cache_if.addr;
                end else if (!empty) begin
                    state_d     = S_DRAIN;
                    mem_write_d = 1'b1;
                    mem_addr_d  = fifo_addr_q[rd_ptr_q];
                    mem_wdata_d = fifo_data_q[rd_ptr_q];
                end
            end

            S_DRAIN: begin
                if (mem_if.ready) begin
                    do_deq      = 1'b1;
                    mem_write_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            S_READ: begin
                if (mem_if.ready) begin
                    cache_ready_d = 1'b1;
                    cache_rdata_d = mem_if.rdata;
                    mem_read_d    = 1'b0;
                    state_d       = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase

        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cache_ready_q <= 1'b0;
            cache_rdata_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cache_ready_q <= cache_ready_d;
            cache_rdata_q <= cache_rdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            fifo_addr_q[wr_ptr_q] <= cache_if.addr;
            fifo_data_q[wr_ptr_q] <= cache_if.wdata;
        end
    end

    assign cache_if.ready = cache_ready_q;
    assign cache_if.rdata = cache_rdata_q;
    assign mem_if.read    = mem_read_q;
    assign mem_if.write   = mem_write_q;
    assign mem_if.addr    = mem_addr_q;
    assign mem_if.wdata   = mem_wdata_q;

endmodule

// File: tb/tb_write_buffer_ctrl.sv
// tb_write_buffer_ctrl
// ---------------------------------------------------------------------------
// Drives write_buffer_ctrl from a cache-side stimulus process and answers its
// memory requests from a memory model with programmable latency. Expected
// values come from a reference view of the system:
//   shadow    - what a read must return: youngest accepted write per address,
//               otherwise memory contents
//   exp_wq    - accepted writes in order, popped as memory completes them
//   occ       - writes accepted but not yet completed at memory
// The build option WB_FORWARD_EN selects which read-ordering rules apply.
// ---------------------------------------------------------------------------
module tb_write_buffer_ctrl;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    write_buffer_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cif ();
    write_buffer_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    write_buffer_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cache_if (cif),
        .mem_if   (mif)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               exp_wq [$];
    logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] shadow    [logic [ADDR_W-1:0]];

    int n_checks     = 0;
    int n_errors     = 0;
    int occ          = 0;
    int mem_lat      = 3;
    int rd_issue_cnt = 0;
    int rd_occ_snap  = -1;
    logic [ADDR_W-1:0] last_rd_addr = '0;

    bit  mm_busy = 1'b0;
    int  mm_cnt  = 0;
    wr_t mm_e;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        return {4{a, 4'h5}};
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Memory model: acts on the falling edge, drives a one-cycle mem_ready
    // after mem_lat cycles and checks drain order against exp_wq.
    initial begin
        mif.ready = 1'b0;
        mif.rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mm_busy   = 1'b0;
                mif.ready = 1'b0;
            end else begin
                if (mif.read || mif.write)
                    chk("rw_excl", DATA_W'(mif.read & mif.write), '0);
                if (mif.ready) begin
                    mif.ready = 1'b0;
                    mm_busy   = 1'b0;
                    chk("req_gap", DATA_W'(mif.read | mif.write), '0);
                end else begin
                    if (!mm_busy && (mif.read || mif.write)) begin
                        mm_busy = 1'b1;
                        mm_cnt  = mem_lat;
                        if (mif.read) begin
                            rd_issue_cnt++;
                            last_rd_addr = mif.addr;
                        end
                    end
                    if (mm_busy) begin
                        if (mm_cnt > 1) begin
                            mm_cnt--;
                        end else begin
                            mif.ready = 1'b1;
                            if (mif.write) begin
                                chk("wr_expected", DATA_W'(exp_wq.size() != 0), DATA_W'(1));
                                if (exp_wq.size() != 0) begin
                                    mm_e = exp_wq.pop_front();
                                    chk("wr_addr", DATA_W'(mif.addr), DATA_W'(mm_e.a));
                                    chk("wr_data", mif.wdata, mm_e.d);
                                end
                                mem_model[mif.addr] = mif.wdata;
                                occ--;
                            end else begin
                                mif.rdata = mem_model.exists(mif.addr) ?
                                            mem_model[mif.addr] : dflt(mif.addr);
                                rd_occ_snap = occ;
`ifndef WB_FORWARD_EN
                                chk("rd_after_drain", DATA_W'(occ), '0);
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_cready"}, DATA_W'(cif.ready), '0);
        chk({pfx, "_crdata"}, cif.rdata, '0);
        chk({pfx, "_mread"},  DATA_W'(mif.read), '0);
        chk({pfx, "_mwrite"}, DATA_W'(mif.write), '0);
        chk({pfx, "_maddr"},  DATA_W'(mif.addr), '0);
        chk({pfx, "_mwdata"}, mif.wdata, '0);
    endtask

    // Called at posedge+1; returns at posedge+1 with the ready cycle retired.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output int cyc);
        bit  was_full;
        wr_t e;
        was_full  = (occ >= DEPTH);
        cif.write = 1'b1;
        cif.addr  = a;
        cif.wdata = d;
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!cif.ready && cyc < 400);
        chk("wr_done", DATA_W'(cif.ready), DATA_W'(1));
        cif.write = 1'b0;
        if (cif.ready) begin
            occ++;
            e.a = a;
            e.d = d;
            exp_wq.push_back(e);
            shadow[a] = d;
            if (was_full) chk("wr_stall", DATA_W'(cyc > 1), DATA_W'(1));
            else          chk("wr_lat", DATA_W'(cyc), DATA_W'(1));
        end
        step(1);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output int cyc);
        logic [DATA_W-1:0] exp;
        exp      = shadow.exists(a) ? shadow[a] : dflt(a);
        cif.read = 1'b1;
        cif.addr = a;
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!cif.ready && cyc < 400);
        chk("rd_done", DATA_W'(cif.ready), DATA_W'(1));
        if (cif.ready) chk("rd_data", cif.rdata, exp);
        cif.read = 1'b0;
        step(1);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((occ != 0 || mif.read || mif.write || mif.ready) && n < 1000) begin
            step(1);
            n++;
        end
        step(1);
        chk("drained", DATA_W'(occ), '0);
    endtask

    initial begin
        int cyc;
        int issued0;
        logic [DATA_W-1:0] d1, d2;
        logic [ADDR_W-1:0] ra;

        cif.read  = 1'b0;
        cif.write = 1'b0;
        cif.addr  = '0;
        cif.wdata = '0;
        rst = 1'b1;
        #1;
        chk_outputs_zero("rst");
        @(posedge clk);
        #1;
        step(2);
        rst = 1'b0;
        step(1);

        // Reset in the middle of a drain.
        mem_lat = 20;
        do_write(28'h0000010, rand_data(), cyc);
        chk("drain_start", DATA_W'(mif.write), DATA_W'(1));
        step(2);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        exp_wq.delete();
        occ = 0;
        shadow.delete();
        foreach (mem_model[k]) shadow[k] = mem_model[k];
        @(posedge clk);
        #1;
        step(1);
        rst = 1'b0;
        do_write(28'h0000010, rand_data(), cyc);
        chk("post_rst_wr", DATA_W'(cyc), DATA_W'(1));
        wait_drained();

        // Fill the buffer with a slow memory; the fifth write must stall.
        mem_lat = 12;
        for (int i = 0; i < 5; i++) begin
            do_write(ADDR_W'(32'h10 + i), rand_data(), cyc);
            if (i == 4) chk("fifth_stall", DATA_W'(cyc > 1), DATA_W'(1));
        end
        wait_drained();

        // Write then read the same address.
        mem_lat = 10;
        d1 = rand_data();
        do_write(28'h000000A, d1, cyc);
        issued0 = rd_issue_cnt;
        do_read(28'h000000A, cyc);
`ifdef WB_FORWARD_EN
        chk("fwd_hit_lat", DATA_W'(cyc), DATA_W'(1));
        chk("fwd_no_memrd", DATA_W'(rd_issue_cnt), DATA_W'(issued0));
`else
        chk("rd_via_mem", DATA_W'(rd_issue_cnt), DATA_W'(issued0 + 1));
        chk("rd_addr", DATA_W'(last_rd_addr), DATA_W'(28'h000000A));
`endif
        wait_drained();

        // Two writes to one address, then a read: the younger must win.
        d1 = rand_data();
        d2 = rand_data();
        do_write(28'h000000A, d1, cyc);
        do_write(28'h000000A, d2, cyc);
        do_read(28'h000000A, cyc);
`ifdef WB_FORWARD_EN
        chk("fwd_young_lat", DATA_W'(cyc), DATA_W'(1));
`endif
        wait_drained();
        chk("mem_final_A", mem_model[28'h000000A], d2);

        // Read miss with writes buffered behind an in-flight drain.
        mem_lat = 10;
        do_write(28'h0000030, rand_data(), cyc);
        do_write(28'h0000020, rand_data(), cyc);
        do_write(28'h0000021, rand_data(), cyc);
        do_read(28'h000000B, cyc);
`ifdef WB_FORWARD_EN
        chk("miss_ahead", DATA_W'(rd_occ_snap), DATA_W'(2));
`else
        chk("miss_after", DATA_W'(rd_occ_snap), '0);
`endif
        wait_drained();

        // Randomized mix over a small address pool.
        for (int n = 0; n < 200; n++) begin
            mem_lat = $urandom_range(1, 6);
            ra = ADDR_W'(32'h40 + $urandom_range(0, 5));
            if ($urandom_range(0, 9) < 6) do_write(ra, rand_data(), cyc);
            else                          do_read(ra, cyc);
            step($urandom_range(0, 2));
        end
        wait_drained();
        chk("sb_empty", DATA_W'(exp_wq.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

endmodule
